rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 2, number of MMCM/PLL lock inputs (legal 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, reset hold length after all preconditions are stable (legal 2..65535).
REQ-003 SHALL have parameter CALIB_TIMEOUT, default 1000000, cycles allowed for memory calibration (legal 2..2^24-1).
REQ-004 SHALL have parameter BLINK_LOG2, default 24, fault-LED toggle period exponent.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: aclk and sys_rst; the ports are aclk, then sys_rst.
REQ-006 SHALL have ports: aclk  in  1  sole clock; sys_rst  in  1  async active-high reset.
REQ-007 SHALL have ports: lock_in  in  NUM_LOCKS  async lock flags; perst_n  in  1  async PCIe PERST#, active-low; calib_done  in  1  async memory calibration complete.
REQ-008 SHALL have ports: mem_rst  out  1  active-high reset to memory controller; core_resetn  out  1  active-low reset to AXI fabric; ready  out  1  system up.
REQ-009 SHALL have ports: state_dbg  out  3  FSM encoding; fault_cnt  out  4  calibration-timeout count; LEDn  out  4  active-low status LEDs.

Function
REQ-010 SHALL pass each of lock_in, perst_n and calib_done through a 2-flop synchroniser; "all_ok" = AND of the synchronised locks AND the synchronised perst_n.
REQ-011 SHALL implement FSM states RST=0, WAIT=1, HOLD=2, MEM=3, RUN=4, FAULT=5; state_dbg SHALL equal the current state.
REQ-012 RST SHALL go to WAIT unconditionally on the next clock.
REQ-013 WAIT SHALL go to HOLD, clearing hold_cnt, when all_ok=1.
REQ-014 HOLD SHALL increment hold_cnt each cycle, and SHALL go to MEM on the cycle hold_cnt==HOLD_CYCLES-1; all_ok=0 in HOLD SHALL return to WAIT.
REQ-015 MEM SHALL count cycles in a 24-bit tmo_cnt cleared on entry, and SHALL go to RUN when the synchronised calib_done=1.
REQ-016 If tmo_cnt reaches CALIB_TIMEOUT-1 in MEM without calib_done, the FSM SHALL go to FAULT and fault_cnt SHALL increment, saturating at 15.
REQ-017 FAULT SHALL hold for HOLD_CYCLES cycles, reusing hold_cnt, then go to WAIT.
REQ-018 In MEM or RUN, all_ok=0 SHALL go to WAIT; this check takes priority over the calib_done and timeout checks in the same cycle.
REQ-019 In RUN, loss of the synchronised calib_done SHALL go to FAULT and increment fault_cnt.
REQ-020 Outputs SHALL be registered, taking effect one cycle after the state is entered: mem_rst=0 only in MEM and RUN; core_resetn=1 and ready=1 only in RUN.
REQ-021 The timing chain SHALL be: perst_n/lock rise → at least 2 synchroniser cycles → HOLD_CYCLES hold → mem_rst falls 1 cycle after MEM entry.
REQ-022 LEDn[0] SHALL equal ~(AND of synchronised locks); LEDn[1] SHALL equal ~synchronised calib_done; LEDn[2] SHALL equal ~ready.
REQ-023 LEDn[3] SHALL be 1 (off) when fault_cnt==0; otherwise its behaviour SHALL be as set by REQ-028/REQ-029.
REQ-024 hold_cnt SHALL be 16 bits and tmo_cnt 24 bits; neither SHALL wrap, because the FSM leaves the state at the terminal count.

Reset
REQ-025 While sys_rst=1: state=RST, all counters=0, synchronisers=0, mem_rst=1, core_resetn=0, ready=0, fault_cnt=0, LEDn=4'b1111 (blink divider=0).
REQ-026 Deassertion of sys_rst mid-sequence SHALL always restart from RST; no state survives reset.
REQ-027 fault_cnt SHALL be cleared only by sys_rst, not by all_ok loss.

Configuration
REQ-028 With macro RST_SEQ_LED_BLINK_EN defined, a free-running BLINK_LOG2-bit divider SHALL exist, and LEDn[3] SHALL equal the divider MSB whenever fault_cnt!=0.
REQ-029 Without RST_SEQ_LED_BLINK_EN, no divider SHALL exist, and LEDn[3] SHALL be 0 (steady on) whenever fault_cnt!=0.

Verification
REQ-030 NUM_LOCKS=2, HOLD_CYCLES=16: assert both locks and perst_n, then calib_done 50 cycles after mem_rst falls → mem_rst falls exactly 2+16+1 cycles after the last input rise; core_resetn=1 and ready=1 3 cycles after calib_done rises.
REQ-031 Drop lock_in[1] at hold_cnt=10 → state_dbg returns to 1, mem_rst stays 1; restore lock_in[1] → full 16-cycle hold restarts.
REQ-032 CALIB_TIMEOUT=100, calib_done held 0 → FAULT after 100 MEM cycles, fault_cnt=1, mem_rst=1 for 16 cycles, then retry; 20 timeouts → fault_cnt stays 15.
REQ-033 In RUN, deassert perst_n → core_resetn=0 and mem_rst=1 within 3 cycles; in the same cycle as the timeout, all_ok=0 wins (state=WAIT, fault_cnt unchanged).
REQ-034 Pulse sys_rst during MEM → immediate outputs mem_rst=1, core_resetn=0, LEDn=4'hF, fault_cnt=0; run once with and once without RST_SEQ_LED_BLINK_EN, BLINK_LOG2=4: LEDn[3] toggles every 8 cycles vs steady 0 after a fault.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequences memory and fabric resets from PLL locks, PERST# and calibration, with a calibration watchdog.
// Optional macro RST_SEQ_LED_BLINK_EN makes LEDn[3] blink on faults instead of staying lit.
module rst_seq_ctrl #(
    parameter int NUM_LOCKS     = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int CALIB_TIMEOUT = 1000000,
    parameter int BLINK_LOG2    = 24
) (
    input  logic                 aclk,
    input  logic                 sys_rst,
    input  logic [NUM_LOCKS-1:0] lock_in,
    input  logic                 perst_n,
    input  logic                 calib_done,
    output logic                 mem_rst,
    output logic                 core_resetn,
    output logic                 ready,
    output logic [2:0]           state_dbg,
    output logic [3:0]           fault_cnt,
    output logic [3:0]           LEDn
);
    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_MEM   = 3'd3,
        S_RUN   = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [23:0] TMO_LAST  = 24'(CALIB_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [NUM_LOCKS-1:0] lock_meta_q, lock_sync_q;
    logic                 perst_meta_q, perst_sync_q, calib_meta_q, calib_sync_q;
    logic [15:0]          hold_cnt_q, hold_cnt_d;
    logic [23:0]          tmo_cnt_q, tmo_cnt_d;
    logic [3:0]           fault_cnt_q, fault_cnt_d;
    logic                 mem_rst_q, mem_rst_d, core_resetn_q, core_resetn_d, ready_q, ready_d;
    logic                 all_ok, fault_inc, fault_led;

    assign all_ok = (&lock_sync_q) & perst_sync_q;

    always_ff @(posedge aclk or posedge sys_rst) begin
        if (sys_rst) begin
            lock_meta_q   <= '0;
            lock_sync_q   <= '0;
            perst_meta_q  <= 1'b0;
            perst_sync_q  <= 1'b0;
            calib_meta_q  <= 1'b0;
            calib_sync_q  <= 1'b0;
            state_q       <= S_RST;
            hold_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            fault_cnt_q   <= '0;
            mem_rst_q     <= 1'b1;
            core_resetn_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            lock_meta_q   <= lock_in;
            lock_sync_q   <= lock_meta_q;
            perst_meta_q  <= perst_n;
            perst_sync_q  <= perst_meta_q;
            calib_meta_q  <= calib_done;
            calib_sync_q  <= calib_meta_q;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            fault_cnt_q   <= fault_cnt_d;
            mem_rst_q     <= mem_rst_d;
            core_resetn_q <= core_resetn_d;
            ready_q       <= ready_d;
        end
    end

    // Loss of all_ok is tested first in every live state so it beats calibration and timeout events.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        fault_inc  = 1'b0;
        case (state_q)
            S_RST: state_d = S_WAIT;
            S_WAIT: begin
                if (all_ok) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (!all_ok) state_d = S_WAIT;
                else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = S_MEM;
                    tmo_cnt_d = '0;
                end else hold_cnt_d = hold_cnt_q + 16'd1;
            end
            S_MEM: begin
                if (!all_ok) state_d = S_WAIT;
                else if (calib_sync_q) state_d = S_RUN;
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = S_FAULT;
                    hold_cnt_d = '0;
                    fault_inc  = 1'b1;
                end else tmo_cnt_d = tmo_cnt_q + 24'd1;
            end
            S_RUN: begin
                if (!all_ok) state_d = S_WAIT;
                else if (!calib_sync_q) begin
                    state_d    = S_FAULT;
                    hold_cnt_d = '0;
                    fault_inc  = 1'b1;
                end
            end
            S_FAULT: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_WAIT;
                else hold_cnt_d = hold_cnt_q + 16'd1;
            end
            default: state_d = S_RST;
        endcase
        fault_cnt_d   = (fault_inc && fault_cnt_q != 4'hF) ? fault_cnt_q + 4'd1 : fault_cnt_q;
        mem_rst_d     = !(state_q == S_MEM || state_q == S_RUN);
        core_resetn_d = state_q == S_RUN;
        ready_d       = state_q == S_RUN;
    end

`ifdef RST_SEQ_LED_BLINK_EN
    logic [BLINK_LOG2-1:0] blink_q, blink_d;

    always_comb blink_d = blink_q + BLINK_LOG2'(1);

    always_ff @(posedge aclk or posedge sys_rst) begin
        if (sys_rst) blink_q <= '0;
        else blink_q <= blink_d;
    end

    assign fault_led = blink_q[BLINK_LOG2-1];
`else
    assign fault_led = 1'b0;
`endif

    assign mem_rst     = mem_rst_q;
    assign core_resetn = core_resetn_q;
    assign ready       = ready_q;
    assign state_dbg   = state_q;
    assign fault_cnt   = fault_cnt_q;
    assign LEDn        = {(fault_cnt_q == 4'd0) ? 1'b1 : fault_led, ~ready_q, ~calib_sync_q, ~(&lock_sync_q)};
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed checks of the reset sequencer with HOLD_CYCLES=16, CALIB_TIMEOUT=100, BLINK_LOG2=4.
module tb_rst_seq_ctrl;
    logic       aclk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] lock_in = 2'b00;
    logic       perst_n = 1'b0;
    logic       calib_done = 1'b0;
    logic       mem_rst, core_resetn, ready;
    logic [2:0] state_dbg;
    logic [3:0] fault_cnt, LEDn;
    int         checks = 0;
    int         errors = 0;

    rst_seq_ctrl #(
        .NUM_LOCKS(2),
        .HOLD_CYCLES(16),
        .CALIB_TIMEOUT(100),
        .BLINK_LOG2(4)
    ) dut (
        .aclk(aclk),
        .sys_rst(sys_rst),
        .lock_in(lock_in),
        .perst_n(perst_n),
        .calib_done(calib_done),
        .mem_rst(mem_rst),
        .core_resetn(core_resetn),
        .ready(ready),
        .state_dbg(state_dbg),
        .fault_cnt(fault_cnt),
        .LEDn(LEDn)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
        int n = 0;
        while (state_dbg !== s && n < lim) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v;
        int   k;
        tick(2);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_mem_rst", 32'(mem_rst), 32'd1);
        chk("rst_core_resetn", 32'(core_resetn), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("rst_LEDn", 32'(LEDn), 32'hF);
        sys_rst = 1'b0;
        tick(1);
        chk("wait_after_rst", 32'(state_dbg), 32'd1);
        tick(3);
        chk("wait_no_inputs", 32'(state_dbg), 32'd1);

        // Inputs rise; edge E0 captures them, E2 enters HOLD, hold_cnt=10 after E12.
        lock_in = 2'b11;
        perst_n = 1'b1;
        tick(2);
        chk("lock_led_on", 32'(LEDn[0]), 32'd0);
        tick(1);
        chk("hold_entry", 32'(state_dbg), 32'd2);
        tick(10);
        lock_in[1] = 1'b0;
        tick(2);
        chk("hold_before_drop", 32'(state_dbg), 32'd2);
        tick(1);
        chk("drop_to_wait", 32'(state_dbg), 32'd1);
        chk("drop_mem_rst", 32'(mem_rst), 32'd1);

        // Restored lock: MEM entered at R18, mem_rst falls at R19 (2 sync + 16 hold + 1).
        lock_in[1] = 1'b1;
        tick(2);
        chk("restore_still_wait", 32'(state_dbg), 32'd1);
        tick(1);
        chk("rehold_entry", 32'(state_dbg), 32'd2);
        tick(15);
        chk("hold_full_length", 32'(state_dbg), 32'd2);
        tick(1);
        chk("mem_entry", 32'(state_dbg), 32'd3);
        chk("mem_rst_r18", 32'(mem_rst), 32'd1);
        tick(1);
        chk("mem_rst_r19", 32'(mem_rst), 32'd0);
        chk("core_in_mem", 32'(core_resetn), 32'd0);

        tick(50);
        calib_done = 1'b1;
        tick(2);
        chk("calib_led", 32'(LEDn[1]), 32'd0);
        chk("mem_before_run", 32'(state_dbg), 32'd3);
        tick(1);
        chk("run_entry", 32'(state_dbg), 32'd4);
        chk("core_c2", 32'(core_resetn), 32'd0);
        tick(1);
        chk("core_c3", 32'(core_resetn), 32'd1);
        chk("ready_c3", 32'(ready), 32'd1);
        chk("run_LEDn", 32'(LEDn), 32'h8);

        tick(5);
        perst_n = 1'b0;
        tick(2);
        chk("run_before_perst", 32'(state_dbg), 32'd4);
        tick(1);
        chk("perst_to_wait", 32'(state_dbg), 32'd1);
        chk("core_p2", 32'(core_resetn), 32'd1);
        tick(1);
        chk("core_p3", 32'(core_resetn), 32'd0);
        chk("mem_rst_p3", 32'(mem_rst), 32'd1);
        chk("ready_p3", 32'(ready), 32'd0);

        // Calibration timeout: MEM at R18, tmo_cnt=99 after R117, FAULT at R118, WAIT at R134.
        calib_done = 1'b0;
        perst_n = 1'b1;
        tick(3);
        chk("to_hold", 32'(state_dbg), 32'd2);
        tick(16);
        chk("to_mem", 32'(state_dbg), 32'd3);
        tick(99);
        chk("tmo_last_mem", 32'(state_dbg), 32'd3);
        chk("tmo_fault_before", 32'(fault_cnt), 32'd0);
        tick(1);
        chk("tmo_fault_state", 32'(state_dbg), 32'd5);
        chk("tmo_fault_cnt", 32'(fault_cnt), 32'd1);
`ifndef RST_SEQ_LED_BLINK_EN
        chk("fault_led_steady", 32'(LEDn[3]), 32'd0);
`endif
        tick(1);
        chk("fault_mem_rst", 32'(mem_rst), 32'd1);
        tick(14);
        chk("fault_last", 32'(state_dbg), 32'd5);
        tick(1);
        chk("fault_to_wait", 32'(state_dbg), 32'd1);
        tick(1);
        chk("retry_hold", 32'(state_dbg), 32'd2);

        // Drop perst_n so all_ok falls in the very cycle tmo_cnt hits its terminal count.
        wait_state("retry_mem", 3'd3, 40);
        tick(97);
        perst_n = 1'b0;
        tick(2);
        chk("race_pre", 32'(state_dbg), 32'd3);
        tick(1);
        chk("race_state", 32'(state_dbg), 32'd1);
        chk("race_fault_cnt", 32'(fault_cnt), 32'd1);

        perst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            wait_state("sat_fault", 3'd5, 300);
            if (i == 0) chk("fault_cnt_2", 32'(fault_cnt), 32'd2);
            wait_state("sat_wait", 3'd1, 40);
        end
        chk("fault_cnt_sat", 32'(fault_cnt), 32'd15);

`ifdef RST_SEQ_LED_BLINK_EN
        v = LEDn[3];
        k = 0;
        while (LEDn[3] === v && k < 9) begin
            tick(1);
            k++;
        end
        chk("blink_first_toggle", 32'(k <= 8), 32'd1);
        v = LEDn[3];
        for (int j = 1; j <= 8; j++) begin
            tick(1);
            chk("blink_period", 32'(LEDn[3]), 32'(j < 8 ? v : ~v));
        end
`else
        v = 1'b0;
        k = 0;
        for (int j = 0; j < 16; j++) begin
            tick(1);
            chk("led3_steady", 32'(LEDn[3]), 32'd0);
        end
`endif

        wait_state("pre_rst_mem", 3'd3, 200);
        tick(2);
        chk("pre_rst_mem_rst", 32'(mem_rst), 32'd0);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_state", 32'(state_dbg), 32'd0);
        chk("async_mem_rst", 32'(mem_rst), 32'd1);
        chk("async_core", 32'(core_resetn), 32'd0);
        chk("async_LEDn", 32'(LEDn), 32'hF);
        chk("async_fault_cnt", 32'(fault_cnt), 32'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        chk("restart_wait", 32'(state_dbg), 32'd1);
        tick(2);
        chk("restart_hold", 32'(state_dbg), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
